// File: rtl/mul_tree_arbiter_if.sv
// Client/tree bundle for mul_tree_arbiter.
// slave = arbiter view, master = clients plus tree.
interface mul_tree_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [63:0]           rsp_data;
  logic                  rsp_ovf;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [63:0]           mul_out;
  logic                  mul_ovf;

  modport slave (
    input  req,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    input  mul_out,
    input  mul_ovf,
    output gnt,
    output rsp_valid,
    output rsp_data,
    output rsp_ovf,
    output mul_a,
    output mul_b
  );

  modport master (
    output req,
    output req_a,
    output req_b,
    output rsp_ready,
    output mul_out,
    output mul_ovf,
    input  gnt,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_ovf,
    input  mul_a,
    input  mul_b
  );
endinterface

// File: rtl/mul_tree_arbiter.sv
// Round-robin sharing of one combinational 32x32 multiplier tree,
// with the tree treated as a MUL_CYCLES multicycle path.
module mul_tree_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_tree_arbiter_if.slave bus,
  output logic             busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win;
  logic               found;
  logic [31:0]        win_a;
  logic [31:0]        win_b;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] valid_q;
  logic [63:0]        data_q;
  logic               ovf_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               own_ready;
  logic               take;
  logic               capture;
  logic               release_rsp;

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin : pick
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
        win_a = bus.req_a[32*idx +: 32];
        win_b = bus.req_b[32*idx +: 32];
      end
    end
  end

  // valid_q is one-hot on the owner, so this is rsp_ready[owner].
  assign own_ready = |(bus.rsp_ready & valid_q);

  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          take      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (own_ready) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      owner   <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      if (take) begin
        a_q    <= win_a;
        b_q    <= win_b;
        owner  <= win;
        cnt    <= CW'(MUL_CYCLES - 1);
        rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0
                                           : win + 1'b1;
      end
      if (state == CALC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        data_q  <= bus.mul_out;
        ovf_q   <= bus.mul_ovf;
        valid_q <= NUM_REQ'(1) << owner;
      end
      if (release_rsp) begin
        valid_q <= '0;
      end
    end
  end

  assign bus.gnt       = take ? (NUM_REQ'(1) << win) : '0;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_ovf   = ovf_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign busy          = (state != IDLE);
endmodule
